// File: rtl/sb_pkg.sv
// Shared sideband receive constants, state encodings and the CRC-16 byte step.
package sb_pkg;

    localparam logic [7:0]  SB_DLE      = 8'hFE;
    localparam logic [7:0]  SB_STX_LT   = 8'h02;
    localparam logic [7:0]  SB_STX_AT   = 8'h03;
    localparam logic [7:0]  SB_ETX      = 8'h40;
    localparam logic [15:0] SB_CRC_POLY = 16'h8005;
    localparam logic [15:0] SB_CRC_INIT = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_EXP_STX,
        ST_PAYLOAD,
        ST_PAY_DLE
    } sb_state_t;

    typedef enum logic [1:0] {
        DF_WAIT_IDLE,
        DF_IDLE,
        DF_DATA,
        DF_STOP
    } sb_df_state_t;

    typedef enum logic {
        SB_LT = 1'b0,
        SB_AT = 1'b1
    } sb_trans_t;

    // One byte through the CRC register, MSB first, no reflection.
    function automatic logic [15:0] sb_crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ data[i]) begin
                c = (c << 1) ^ SB_CRC_POLY;
            end else begin
                c = c << 1;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/sb_rx_decoder_if.sv
// Serial input and decoded-transaction outputs of the sideband receive decoder.
interface sb_rx_decoder_if #(
    parameter int unsigned MAX_PAYLOAD = 16
);
    localparam int unsigned LEN_W  = $clog2(MAX_PAYLOAD + 1);
    localparam int unsigned DATA_W = 8 * MAX_PAYLOAD;

    logic              sbrx;
    logic              trans_valid;
    logic              trans_type;
    logic [LEN_W-1:0]  trans_len;
    logic [DATA_W-1:0] trans_data;
    logic              crc_err;
    logic              frame_err;
    logic              busy;

    modport master (
        input  sbrx,
        output trans_valid, trans_type, trans_len, trans_data, crc_err, frame_err, busy
    );

    modport slave (
        output sbrx,
        input  trans_valid, trans_type, trans_len, trans_data, crc_err, frame_err, busy
    );
endinterface

// File: rtl/sb_rx_deframer.sv
// Bit-level UART deframer: start 0, 8 data bits LSB first, stop 1; one bit per clock.
module sb_rx_deframer
    import sb_pkg::*;
(
    input  logic       sb_clk,
    input  logic       rst,
    input  logic       sbrx,
    output logic       byte_vld,
    output logic [7:0] byte_data,
    output logic       stop_err
);

    sb_df_state_t state;
    logic [2:0]   bit_cnt;
    logic [7:0]   shreg;

    // The shift register is stable while byte_vld is high, so it doubles as the byte output.
    assign byte_data = shreg;

    always_ff @(posedge sb_clk or negedge rst) begin
        if (!rst) begin
            state    <= DF_WAIT_IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            byte_vld <= 1'b0;
            stop_err <= 1'b0;
        end else begin
            byte_vld <= 1'b0;
            stop_err <= 1'b0;
            case (state)
                DF_WAIT_IDLE: begin
                    if (sbrx) state <= DF_IDLE;
                end
                DF_IDLE: begin
                    if (!sbrx) begin
                        state   <= DF_DATA;
                        bit_cnt <= '0;
                    end
                end
                DF_DATA: begin
                    shreg   <= {sbrx, shreg[7:1]};
                    bit_cnt <= bit_cnt + 3'(1);
                    if (bit_cnt == 3'(7)) state <= DF_STOP;
                end
                DF_STOP: begin
                    if (sbrx) begin
                        byte_vld <= 1'b1;
                        state    <= DF_IDLE;
                    end else begin
                        stop_err <= 1'b1;
                        state    <= DF_WAIT_IDLE;
                    end
                end
                default: state <= DF_WAIT_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/sb_rx_decoder.sv
// Sideband receive decoder: deframes sbrx, removes DLE stuffing, validates LT/AT transactions.
// Define SB_RX_CRC_EN to build the CRC-16 check on AT transactions; otherwise crc_err is 0.
module sb_rx_decoder
    import sb_pkg::*;
#(
    parameter int unsigned MAX_PAYLOAD = 16
) (
    input  logic            sb_clk,
    input  logic            rst,
    sb_rx_decoder_if.master bus
);

    localparam int unsigned BUF_N  = MAX_PAYLOAD + 2;
    localparam int unsigned CNT_W  = $clog2(BUF_N + 1);
    localparam int unsigned LEN_W  = $clog2(MAX_PAYLOAD + 1);
    localparam int unsigned DATA_W = 8 * MAX_PAYLOAD;

    logic       byte_vld;
    logic       stop_err;
    logic [7:0] byte_data;

    sb_rx_deframer u_deframer (
        .sb_clk    (sb_clk),
        .rst       (rst),
        .sbrx      (bus.sbrx),
        .byte_vld  (byte_vld),
        .byte_data (byte_data),
        .stop_err  (stop_err)
    );

    sb_state_t         state;
    sb_trans_t         cur_type;
    logic [CNT_W-1:0]  cnt;
    logic [7:0]        buf_q [BUF_N];
    logic              busy_q;
    logic              valid_q;
    logic              frame_err_q;
    sb_trans_t         type_q;
    logic [LEN_W-1:0]  len_q;
    logic [DATA_W-1:0] data_q;

    logic              is_dle_c;
    logic              is_etx_c;
    logic              is_stx_c;
    sb_trans_t         stx_type_c;
    logic              full_c;
    logic              app_c;
    logic              start_c;
    logic              end_ok_c;
    logic              crc_ok_c;
    logic [CNT_W-1:0]  end_len_c;
    logic [DATA_W-1:0] data_c;

    // Byte classification and buffer bookkeeping for the current received byte.
    always_comb begin
        is_dle_c   = (byte_data == SB_DLE);
        is_etx_c   = (byte_data == SB_ETX);
        is_stx_c   = (byte_data == SB_STX_LT) || (byte_data == SB_STX_AT);
        stx_type_c = (byte_data == SB_STX_AT) ? SB_AT : SB_LT;
        full_c     = (cur_type == SB_AT) ? (cnt == CNT_W'(BUF_N)) : (cnt == CNT_W'(1));
        app_c      = byte_vld && !full_c &&
                     (((state == ST_PAYLOAD) && !is_dle_c) || ((state == ST_PAY_DLE) && is_dle_c));
        start_c    = byte_vld && is_stx_c && ((state == ST_EXP_STX) || (state == ST_PAY_DLE));
        end_ok_c   = (cur_type == SB_AT) ? (cnt >= CNT_W'(3)) : (cnt == CNT_W'(1));
        end_len_c  = (cur_type == SB_AT) ? (cnt - CNT_W'(2)) : cnt;
    end

    // Payload view with CRC bytes and stale entries masked to zero.
    always_comb begin
        data_c = '0;
        for (int i = 0; i < int'(MAX_PAYLOAD); i++) begin
            if (CNT_W'(i) < end_len_c) data_c[8*i +: 8] = buf_q[i];
        end
    end

    always_ff @(posedge sb_clk) begin
        if (app_c) buf_q[cnt] <= byte_data;
    end

`ifdef SB_RX_CRC_EN
    logic [15:0] crc_q;
    logic        crc_err_q;

    // Runs over every destuffed byte after STX; a clean frame leaves a zero residue.
    always_ff @(posedge sb_clk or negedge rst) begin
        if (!rst) begin
            crc_q <= SB_CRC_INIT;
        end else if (start_c) begin
            crc_q <= SB_CRC_INIT;
        end else if (app_c) begin
            crc_q <= sb_crc16_byte(crc_q, byte_data);
        end
    end

    assign crc_ok_c    = (crc_q == 16'h0000);
    assign bus.crc_err = crc_err_q;
`else
    assign crc_ok_c    = 1'b1;
    assign bus.crc_err = 1'b0;
`endif

    always_ff @(posedge sb_clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_HUNT;
            cur_type    <= SB_LT;
            cnt         <= '0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            type_q      <= SB_LT;
            len_q       <= '0;
            data_q      <= '0;
`ifdef SB_RX_CRC_EN
            crc_err_q   <= 1'b0;
`endif
        end else begin
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef SB_RX_CRC_EN
            crc_err_q   <= 1'b0;
`endif
            if (stop_err) begin
                frame_err_q <= 1'b1;
                state       <= ST_HUNT;
                busy_q      <= 1'b0;
            end else if (start_c) begin
                // DLE STX inside a payload aborts the old transaction and opens the new one.
                frame_err_q <= (state == ST_PAY_DLE);
                state       <= ST_PAYLOAD;
                cur_type    <= stx_type_c;
                cnt         <= '0;
                busy_q      <= 1'b1;
            end else if (app_c) begin
                cnt   <= cnt + CNT_W'(1);
                state <= ST_PAYLOAD;
            end else if (byte_vld) begin
                case (state)
                    ST_HUNT: begin
                        if (is_dle_c) state <= ST_EXP_STX;
                    end
                    ST_EXP_STX: begin
                        if (!is_dle_c) state <= ST_HUNT;
                    end
                    ST_PAYLOAD: begin
                        if (is_dle_c) begin
                            state <= ST_PAY_DLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state       <= ST_HUNT;
                            busy_q      <= 1'b0;
                        end
                    end
                    ST_PAY_DLE: begin
                        state  <= ST_HUNT;
                        busy_q <= 1'b0;
                        if (!is_etx_c || !end_ok_c) begin
                            frame_err_q <= 1'b1;
                        end else if (crc_ok_c) begin
                            valid_q <= 1'b1;
                            type_q  <= cur_type;
                            len_q   <= LEN_W'(end_len_c);
                            data_q  <= data_c;
                        end
`ifdef SB_RX_CRC_EN
                        else begin
                            crc_err_q <= 1'b1;
                        end
`endif
                    end
                    default: state <= ST_HUNT;
                endcase
            end
        end
    end

    assign bus.trans_valid = valid_q;
    assign bus.trans_type  = type_q;
    assign bus.trans_len   = len_q;
    assign bus.trans_data  = data_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_sb_rx_decoder.sv
// Directed bench for sb_rx_decoder: table of symbol streams plus reset and busy sequences.
module tb_sb_rx_decoder;

    localparam int unsigned MP = 16;
    localparam int PERIOD = 10;

    logic sb_clk;
    logic rst;

    sb_rx_decoder_if #(.MAX_PAYLOAD(MP)) bus ();

    sb_rx_decoder #(.MAX_PAYLOAD(MP)) dut (
        .sb_clk (sb_clk),
        .rst    (rst),
        .bus    (bus)
    );

    initial begin
        sb_clk = 1'b0;
        forever #(PERIOD / 2) sb_clk = ~sb_clk;
    end

    typedef struct {
        logic [8*48-1:0] sym;
        int              n;
        int              bad;
        int              n_valid;
        int              n_crc;
        int              n_frame;
        logic            ttype;
        int              len;
        logic [127:0]    data;
    } vec_t;

    vec_t v;
    vec_t vtab[$];

    int  n_checks = 0;
    int  n_fail   = 0;
    int  cnt_v, cnt_c, cnt_f;
    int  n_coincide = 0;
    time res_t, last_stop_t;
    logic last_busy;

    // Pulse monitor, sampled mid-cycle.
    always @(negedge sb_clk) begin
        if (bus.trans_valid) begin cnt_v++; res_t = $time; end
        if (bus.crc_err)     begin cnt_c++; res_t = $time; end
        if (bus.frame_err)   cnt_f++;
        if (bus.trans_valid || bus.crc_err || bus.frame_err) last_busy = bus.busy;
        if (bus.trans_valid && (bus.crc_err || bus.frame_err)) n_coincide++;
    end

    function automatic logic [15:0] gold_crc(input logic [15:0] c_in, input logic [7:0] d);
        logic [15:0] c;
        c = c_in ^ {d, 8'h00};
        for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h8005) : (c << 1);
        return c;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge sb_clk);
        bus.sbrx = b;
    endtask

    task automatic send_sym(input logic [7:0] d, input bit stop_ok);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop_ok);
        last_stop_t = $time;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    task automatic vnew();
        v.sym = '0; v.n = 0; v.bad = -1;
    endtask

    task automatic vb(input logic [7:0] b);
        v.sym[8*v.n +: 8] = b;
        v.n++;
    endtask

    task automatic vstuff(input logic [7:0] b);
        vb(b);
        if (b == 8'hFE) vb(8'hFE);
    endtask

    task automatic vexp(input int nv, input int nc, input int nf,
                        input logic t, input int len, input logic [127:0] d);
        v.n_valid = nv; v.n_crc = nc; v.n_frame = nf;
        v.ttype = t; v.len = len; v.data = d;
        vtab.push_back(v);
    endtask

    task automatic at_frame(input logic [127:0] pl, input int n, input bit flip);
        logic [15:0] c;
        logic [7:0]  b;
        c = 16'hFFFF;
        vb(8'hFE); vb(8'h03);
        for (int i = 0; i < n; i++) begin
            b = pl[8*i +: 8];
            c = gold_crc(c, b);
            vstuff(b);
        end
        vstuff(c[15:8]);
        vstuff(c[7:0] ^ (flip ? 8'h01 : 8'h00));
        vb(8'hFE); vb(8'h40);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_valid"}, 128'(bus.trans_valid), 128'd0);
        chk({tag, "_type"},  128'(bus.trans_type),  128'd0);
        chk({tag, "_len"},   128'(bus.trans_len),   128'd0);
        chk({tag, "_data"},  128'(bus.trans_data),  128'd0);
        chk({tag, "_crc"},   128'(bus.crc_err),     128'd0);
        chk({tag, "_frame"}, 128'(bus.frame_err),   128'd0);
        chk({tag, "_busy"},  128'(bus.busy),        128'd0);
    endtask

    initial begin
        logic [127:0] pl;
        int nv2, nc2;

        rst = 1'b0;
        bus.sbrx = 1'b1;
        repeat (2) @(negedge sb_clk);
        check_outputs_zero("reset");
        rst = 1'b1;
        idle(4);

        // 0: LT 5A
        vnew(); vb(8'hFE); vb(8'h02); vb(8'h5A); vb(8'hFE); vb(8'h40);
        vexp(1, 0, 0, 1'b0, 1, 128'h5A);
        // 1: AT 01 FE 00 with good CRC
        pl = 128'h00FE01;
        vnew(); at_frame(pl, 3, 1'b0);
        vexp(1, 0, 0, 1'b1, 3, 128'h00FE01);
        // 2: same AT with a flipped CRC bit
`ifdef SB_RX_CRC_EN
        nv2 = 0; nc2 = 1;
`else
        nv2 = 1; nc2 = 0;
`endif
        vnew(); at_frame(pl, 3, 1'b1);
        vexp(nv2, nc2, 0, 1'b1, 3, 128'h00FE01);
        // 3: stop bit low mid-payload
        vnew(); vb(8'hFE); vb(8'h03); vb(8'h11); vb(8'h22); v.bad = 3;
        vexp(0, 0, 1, 1'b1, 3, 128'h00FE01);
        // 4: recovery LT C3
        vnew(); vb(8'hFE); vb(8'h02); vb(8'hC3); vb(8'hFE); vb(8'h40);
        vexp(1, 0, 0, 1'b0, 1, 128'hC3);
        // 5: AT aborted by DLE STX_LT, then LT 7E
        vnew(); vb(8'hFE); vb(8'h03); vb(8'hAA); vb(8'hFE); vb(8'h02); vb(8'h7E); vb(8'hFE); vb(8'h40);
        vexp(1, 0, 1, 1'b0, 1, 128'h7E);
        // 6: AT overflow with MP+3 data bytes
        vnew(); vb(8'hFE); vb(8'h03);
        for (int i = 1; i <= int'(MP) + 3; i++) vb(8'(i));
        vb(8'hFE); vb(8'h40);
        vexp(0, 0, 1, 1'b0, 1, 128'h7E);
        // 7: AT with exactly MP data bytes
        for (int i = 0; i < int'(MP); i++) pl[8*i +: 8] = 8'hA0 + 8'(i);
        vnew(); at_frame(pl, int'(MP), 1'b0);
        vexp(1, 0, 0, 1'b1, int'(MP), pl);
        // 8: LT with two bytes
        vnew(); vb(8'hFE); vb(8'h02); vb(8'h11); vb(8'h22); vb(8'hFE); vb(8'h40);
        vexp(0, 0, 1, 1'b1, int'(MP), pl);
        // 9: AT with only two bytes
        vnew(); vb(8'hFE); vb(8'h03); vb(8'h11); vb(8'h22); vb(8'hFE); vb(8'h40);
        vexp(0, 0, 1, 1'b1, int'(MP), pl);
        // 10: LT with no bytes
        vnew(); vb(8'hFE); vb(8'h02); vb(8'hFE); vb(8'h40);
        vexp(0, 0, 1, 1'b1, int'(MP), pl);
        // 11: leading garbage and doubled DLE before STX
        vnew(); vb(8'h55); vb(8'hFE); vb(8'hFE); vb(8'h02); vb(8'h33); vb(8'hFE); vb(8'h40);
        vexp(1, 0, 0, 1'b0, 1, 128'h33);
        // 12: illegal byte after DLE in payload
        vnew(); vb(8'hFE); vb(8'h02); vb(8'h44); vb(8'hFE); vb(8'h77);
        vexp(0, 0, 1, 1'b0, 1, 128'h33);

        foreach (vtab[k]) begin
            cnt_v = 0; cnt_c = 0; cnt_f = 0; res_t = 0; last_busy = 1'b1;
            for (int i = 0; i < vtab[k].n; i++) send_sym(vtab[k].sym[8*i +: 8], i != vtab[k].bad);
            idle(8);
            chk($sformatf("v%0d_valid_cnt", k), 128'(cnt_v), 128'(vtab[k].n_valid));
            chk($sformatf("v%0d_crc_cnt", k),   128'(cnt_c), 128'(vtab[k].n_crc));
            chk($sformatf("v%0d_frame_cnt", k), 128'(cnt_f), 128'(vtab[k].n_frame));
            chk($sformatf("v%0d_type", k), 128'(bus.trans_type), 128'(vtab[k].ttype));
            chk($sformatf("v%0d_len", k),  128'(bus.trans_len),  128'(vtab[k].len));
            chk($sformatf("v%0d_data", k), 128'(bus.trans_data), vtab[k].data);
            chk($sformatf("v%0d_busy_at_pulse", k), 128'(last_busy), 128'd0);
            if (vtab[k].n_valid + vtab[k].n_crc > 0)
                chk($sformatf("v%0d_latency", k), 128'(res_t - last_stop_t), 128'(2 * PERIOD));
        end

        // Reset in the middle of an AT payload.
        cnt_v = 0; cnt_c = 0; cnt_f = 0;
        send_sym(8'hFE, 1'b1); send_sym(8'h03, 1'b1); send_sym(8'h11, 1'b1);
        idle(2);
        chk("busy_mid_payload", 128'(bus.busy), 128'd1);
        @(negedge sb_clk);
        rst = 1'b0;
        #1;
        check_outputs_zero("mid_rst");
        repeat (3) @(negedge sb_clk);
        rst = 1'b1;
        idle(8);
        chk("no_pulse_after_rst", 128'(cnt_v + cnt_c + cnt_f), 128'd0);

        // Clean LT after the reset.
        cnt_v = 0; cnt_c = 0; cnt_f = 0;
        send_sym(8'hFE, 1'b1); send_sym(8'h02, 1'b1); send_sym(8'h96, 1'b1);
        send_sym(8'hFE, 1'b1); send_sym(8'h40, 1'b1);
        idle(8);
        chk("post_rst_valid_cnt", 128'(cnt_v), 128'd1);
        chk("post_rst_frame_cnt", 128'(cnt_f), 128'd0);
        chk("post_rst_data", bus.trans_data, 128'h96);
        chk("pulse_coincide", 128'(n_coincide), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
